// File: rtl/spi_slave_shifter.sv
// Mode-0 SPI slave shift engine driven by pre-synchronised SCLK/CS edge enables.
// Optional sticky receive-overrun flag is enabled by defining SPI_SLV_RX_OVF_EN.
module spi_slave_shifter #(
    parameter int              DW        = 8,
    parameter bit              MSB_FIRST = 1'b1,
    parameter logic [DW-1:0]   TX_FILL   = '1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sclk_rise,
    input  logic          sclk_fall,
    input  logic          cs_fall,
    input  logic          cs_rise,
    input  logic          mosi,
    output logic          miso,
    output logic          miso_oe,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    output logic          rx_ovf
);

    localparam int            CW   = $clog2(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic [CW-1:0]   r_bitCnt;
    logic [DW-1:0]   r_rxSr;
    logic [DW-1:0]   r_txSr;
    logic [DW-1:0]   r_txHold;
    logic            r_txFull;
    logic [DW-1:0]   r_rxData;
    logic            r_rxValid;

    logic            w_frameStart;
    logic            w_frameEnd;
    logic            w_rise;
    logic            w_fall;
    logic            w_wordDone;
    logic            w_txLoad;
    logic            w_rxDrop;
    logic [DW-1:0]   w_rxNext;

    // cs_rise outranks any SCLK edge arriving in the same cycle
    assign w_frameStart = (r_state == IDLE) && cs_fall;
    assign w_frameEnd   = (r_state == ACTIVE) && cs_rise;
    assign w_rise       = (r_state == ACTIVE) && !cs_rise && sclk_rise;
    assign w_fall       = (r_state == ACTIVE) && !cs_rise && sclk_fall;
    assign w_wordDone   = w_rise && (r_bitCnt == LAST);
    assign w_txLoad     = w_frameStart || (w_fall && (r_bitCnt == '0));
    assign w_rxDrop     = w_wordDone && r_rxValid && !rx_ready;
    assign w_rxNext     = MSB_FIRST ? {r_rxSr[DW-2:0], mosi} : {mosi, r_rxSr[DW-1:1]};

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (cs_fall) w_stateNext = ACTIVE;
            ACTIVE:  if (cs_rise) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bitCnt  <= '0;
            r_rxSr    <= '0;
            r_txSr    <= TX_FILL;
            r_txHold  <= '0;
            r_txFull  <= 1'b0;
            r_rxData  <= '0;
            r_rxValid <= 1'b0;
        end else begin
            if (w_frameStart || w_frameEnd) begin
                r_bitCnt <= '0;
                r_rxSr   <= '0;
            end else if (w_rise) begin
                r_rxSr   <= w_rxNext;
                r_bitCnt <= w_wordDone ? '0 : r_bitCnt + CW'(1);
            end

            if (w_txLoad)
                r_txSr <= r_txFull ? r_txHold : TX_FILL;
            else if (w_fall)
                r_txSr <= MSB_FIRST ? {r_txSr[DW-2:0], 1'b0} : {1'b0, r_txSr[DW-1:1]};

            // A load empties a full holding register; a write is only taken when it was already empty
            if (w_txLoad && r_txFull) begin
                r_txFull <= 1'b0;
            end else if (tx_valid && !r_txFull) begin
                r_txFull <= 1'b1;
                r_txHold <= tx_data;
            end

            if (w_wordDone && (!r_rxValid || rx_ready)) begin
                r_rxData  <= w_rxNext;
                r_rxValid <= 1'b1;
            end else if (r_rxValid && rx_ready) begin
                r_rxValid <= 1'b0;
            end
        end
    end

`ifdef SPI_SLV_RX_OVF_EN
    logic r_rxOvf;

    always_ff @(posedge clk) begin
        if (rst)               r_rxOvf <= 1'b0;
        else if (w_rxDrop)     r_rxOvf <= 1'b1;
        else if (w_frameStart) r_rxOvf <= 1'b0;
    end

    assign rx_ovf = r_rxOvf;
`else
    logic w_unusedDrop;
    assign w_unusedDrop = w_rxDrop;
    assign rx_ovf       = 1'b0;
`endif

    assign miso     = MSB_FIRST ? r_txSr[DW-1] : r_txSr[0];
    assign miso_oe  = (r_state == ACTIVE);
    assign tx_ready = !r_txFull;
    assign rx_data  = r_rxData;
    assign rx_valid = r_rxValid;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Self-checking bench for spi_slave_shifter: directed scenarios with literal expectations
// plus randomized frames compared every cycle against a bit-list transaction model.
module tb_spi_slave_shifter;

    localparam int            DW        = 8;
    localparam bit            MSB_FIRST = 1'b1;
    localparam logic [DW-1:0] TX_FILL   = '1;
`ifdef SPI_SLV_RX_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sclk_rise = 1'b0, sclk_fall = 1'b0, cs_fall = 1'b0, cs_rise = 1'b0, mosi = 1'b0;
    logic          miso, miso_oe, tx_ready, rx_valid, rx_ovf;
    logic          tx_valid = 1'b0, rx_ready = 1'b1;
    logic [DW-1:0] tx_data = '0;
    logic [DW-1:0] rx_data;

    always #5 clk = ~clk;

    spi_slave_shifter #(.DW(DW), .MSB_FIRST(MSB_FIRST), .TX_FILL(TX_FILL)) dut (
        .clk(clk), .rst(rst),
        .sclk_rise(sclk_rise), .sclk_fall(sclk_fall), .cs_fall(cs_fall), .cs_rise(cs_rise),
        .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_ovf(rx_ovf)
    );

    int checks   = 0;
    int failures = 0;
    bit randMode = 1'b0;
    logic [DW-1:0] misoCap;

    // Model: a frame is a list of received bits plus an index into the word being transmitted
    bit            mActive;
    int            mBitIdx;
    bit            rxBits[$];
    logic [DW-1:0] mTxWord;
    int            mTxPos;
    logic [DW-1:0] holdQ[$];
    logic [DW-1:0] mRxData;
    bit            mRxValid;
    bit            mOvf;

    function automatic logic [DW-1:0] assembleWord();
        logic [DW-1:0] w = '0;
        for (int i = 0; i < DW; i++)
            if (MSB_FIRST) w[DW-1-i] = rxBits[i];
            else           w[i]      = rxBits[i];
        return w;
    endfunction

    function automatic bit expMiso();
        if (mTxPos >= DW) return 1'b0;
        return MSB_FIRST ? mTxWord[DW-1-mTxPos] : mTxWord[mTxPos];
    endfunction

    function automatic void modelStep();
        bit            holdEmpty = (holdQ.size() == 0);
        bit            txLoad = 1'b0, complete = 1'b0, startFrame = 1'b0, dropped = 1'b0;
        logic [DW-1:0] newWord = '0;
        if (rst) begin
            mActive = 0; mBitIdx = 0; rxBits.delete(); mTxWord = TX_FILL; mTxPos = 0;
            holdQ.delete(); mRxData = '0; mRxValid = 0; mOvf = 0;
            return;
        end
        if (!mActive) begin
            if (cs_fall) begin
                mActive = 1; mBitIdx = 0; rxBits.delete(); txLoad = 1; startFrame = 1;
            end
        end else if (cs_rise) begin
            mActive = 0; mBitIdx = 0; rxBits.delete();
        end else begin
            if (sclk_rise) begin
                rxBits.push_back(mosi);
                mBitIdx++;
                if (mBitIdx == DW) begin
                    complete = 1; newWord = assembleWord(); rxBits.delete(); mBitIdx = 0;
                end
            end
            if (sclk_fall) begin
                if (mBitIdx == 0) txLoad = 1;
                else              mTxPos++;
            end
        end
        if (txLoad) begin
            mTxWord = holdEmpty ? TX_FILL : holdQ.pop_front();
            mTxPos  = 0;
        end
        if (tx_valid && holdEmpty) holdQ.push_back(tx_data);
        if (complete) begin
            if (!mRxValid || rx_ready) begin
                mRxData = newWord; mRxValid = 1;
            end else begin
                dropped = 1;
            end
        end else if (mRxValid && rx_ready) begin
            mRxValid = 0;
        end
        if (OVF_ON && dropped)         mOvf = 1;
        else if (OVF_ON && startFrame) mOvf = 0;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        checkVal("miso",     32'(miso),     32'(expMiso()));
        checkVal("miso_oe",  32'(miso_oe),  32'(mActive));
        checkVal("tx_ready", 32'(tx_ready), 32'(holdQ.size() == 0));
        checkVal("rx_valid", 32'(rx_valid), 32'(mRxValid));
        checkVal("rx_data",  32'(rx_data),  32'(mRxData));
        checkVal("rx_ovf",   32'(rx_ovf),   32'(mOvf));
    endtask

    task automatic applyStimulus(input bit sr, input bit sf, input bit cf, input bit cr, input bit m);
        sclk_rise = sr; sclk_fall = sf; cs_fall = cf; cs_rise = cr; mosi = m;
        if (randMode) begin
            tx_valid = ($urandom_range(0, 3) == 0);
            tx_data  = DW'($urandom);
            rx_ready = $urandom_range(0, 1);
        end
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
        sclk_rise = 0; sclk_fall = 0; cs_fall = 0; cs_rise = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
    endtask

    task automatic gap();
        idle(randMode ? $urandom_range(0, 2) : 1);
    endtask

    task automatic offerTx(input logic [DW-1:0] w);
        tx_valid = 1; tx_data = w;
        applyStimulus(0, 0, 0, 0, 0);
        tx_valid = 0;
    endtask

    task automatic sendBit(input bit b);
        misoCap = {misoCap[DW-2:0], miso};
        applyStimulus(1, 0, 0, 0, b);
        gap();
        applyStimulus(0, 1, 0, 0, 0);
        gap();
    endtask

    task automatic sendWord(input logic [DW-1:0] w);
        for (int i = 0; i < DW; i++) sendBit(MSB_FIRST ? w[DW-1-i] : w[i]);
    endtask

    task automatic startFrame();
        applyStimulus(0, 0, 1, 0, 0);
        gap();
    endtask

    task automatic endFrame();
        applyStimulus(0, 0, 0, 1, 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: bench did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        idle(2);
        rst = 0;
        checkVal("reset miso", 32'(miso), 32'(1));
        checkVal("reset miso_oe", 32'(miso_oe), 32'(0));
        checkVal("reset tx_ready", 32'(tx_ready), 32'(1));
        checkVal("reset rx_valid", 32'(rx_valid), 32'(0));
        checkVal("reset rx_data", 32'(rx_data), 32'(0));
        idle(1);

        // Basic word in both directions
        rx_ready = 0;
        offerTx(8'hA5);
        startFrame();
        sendWord(8'h3C);
        checkVal("basic miso word", 32'(misoCap), 32'h0A5);
        checkVal("basic rx_data", 32'(rx_data), 32'h03C);
        checkVal("basic rx_valid", 32'(rx_valid), 32'(1));
        endFrame();
        rx_ready = 1;
        idle(2);

        // Underrun fill
        startFrame();
        sendWord(8'h00);
        checkVal("underrun miso word", 32'(misoCap), 32'h0FF);
        checkVal("underrun tx_ready", 32'(tx_ready), 32'(1));
        endFrame();
        idle(2);

        // Back-to-back words with holding register refilled mid-word
        offerTx(8'h55);
        startFrame();
        offerTx(8'hAA);
        sendWord(8'h12);
        checkVal("b2b miso word0", 32'(misoCap), 32'h055);
        checkVal("b2b rx_data0", 32'(rx_data), 32'h012);
        sendWord(8'h34);
        checkVal("b2b miso word1", 32'(misoCap), 32'h0AA);
        checkVal("b2b rx_data1", 32'(rx_data), 32'h034);
        endFrame();
        idle(2);

        // Overrun
        rx_ready = 0;
        startFrame();
        sendWord(8'h11);
        sendWord(8'h22);
        checkVal("ovf rx_data", 32'(rx_data), 32'h011);
        checkVal("ovf flag", 32'(rx_ovf), 32'(OVF_ON));
        endFrame();
        idle(1);
        applyStimulus(0, 0, 1, 0, 0);
        checkVal("ovf cleared by cs_fall", 32'(rx_ovf), 32'(0));
        endFrame();
        rx_ready = 1;
        idle(2);

        // Mid-word abort
        startFrame();
        for (int i = 0; i < 5; i++) sendBit(1'b1);
        endFrame();
        checkVal("abort miso_oe", 32'(miso_oe), 32'(0));
        checkVal("abort rx_valid", 32'(rx_valid), 32'(0));
        idle(1);
        startFrame();
        sendWord(8'h81);
        checkVal("abort next word", 32'(rx_data), 32'h081);
        endFrame();
        idle(2);

        // cs_rise colliding with sclk_rise, then reset mid-frame
        startFrame();
        for (int i = 0; i < 3; i++) sendBit(1'b0);
        applyStimulus(1, 0, 0, 1, 1);
        checkVal("collision miso_oe", 32'(miso_oe), 32'(0));
        idle(1);
        startFrame();
        offerTx(8'h3A);
        sendBit(1'b1);
        sendBit(1'b0);
        rst = 1;
        idle(1);
        rst = 0;
        checkVal("rst miso", 32'(miso), 32'(1));
        checkVal("rst miso_oe", 32'(miso_oe), 32'(0));
        checkVal("rst tx_ready", 32'(tx_ready), 32'(1));
        checkVal("rst rx_valid", 32'(rx_valid), 32'(0));
        checkVal("rst rx_data", 32'(rx_data), 32'(0));
        checkVal("rst rx_ovf", 32'(rx_ovf), 32'(0));
        idle(2);

        // Randomized frames: partial words, collisions, stray resets, random handshakes
        randMode = 1;
        for (int f = 0; f < 40; f++) begin
            int nBits;
            startFrame();
            nBits = $urandom_range(0, 3 * DW);
            for (int b = 0; b < nBits; b++) sendBit($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       applyStimulus(1, 0, 0, 1, $urandom_range(0, 1));
                1:       begin applyStimulus(1, 0, 0, 0, 1); applyStimulus(0, 1, 0, 1, 0); end
                2:       begin rst = 1; idle(1); rst = 0; end
                default: endFrame();
            endcase
            idle($urandom_range(0, 3));
        end
        randMode = 0;
        tx_valid = 0;
        rx_ready = 1;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_slave_shifter.md
# spi_slave_shifter

- Mode-0 (CPOL=0, CPHA=0) SPI slave shift engine.
- Sits directly downstream of the SCLK/CS edge-enable synchronisers.
- Consumes their single-cycle rising/falling enables plus the synchronised MOSI level.
- Deserialises received words onto a valid/ready stream and serialises a transmit word onto MISO, all in the system `clk` domain.

## Interface
Parameters:
- `DW`, 8, word width in bits (≥2)
- `MSB_FIRST`, 1, 1 = MSB shifted first, 0 = LSB first
- `TX_FILL`, all ones, word sent when no transmit word is pending

Ports:
- `clk` in 1: system clock; the only clock
- `rst` in 1: synchronous, active-high reset
- `sclk_rise` in 1: one-cycle enable, synchronised SCLK rising edge
- `sclk_fall` in 1: one-cycle enable, synchronised SCLK falling edge
- `cs_fall` in 1: one-cycle enable, CS_n asserted (frame start)
- `cs_rise` in 1: one-cycle enable, CS_n deasserted (frame end)
- `mosi` in 1: synchronised MOSI level, aligned with the edge enables
- `miso` out 1: serial transmit bit
- `miso_oe` out 1: MISO output enable, high while a frame is active
- `tx_data` in DW: transmit word
- `tx_valid` in 1: transmit word offered
- `tx_ready` out 1: transmit holding register empty
- `rx_data` out DW: received word
- `rx_valid` out 1: received word available
- `rx_ready` in 1: consumer accepts `rx_data`
- `rx_ovf` out 1: sticky receive overrun flag (see Configuration)

## Operation
Registers:
- State machine with states IDLE and ACTIVE.
- `bit_cnt`, $clog2(DW) bits.
- `rx_sr` and `tx_sr`, DW bits each.
- One-entry TX holding register and one-entry RX output register.

IDLE:
- `miso_oe`=0; SCLK enables are ignored.
- `cs_fall` → ACTIVE, `bit_cnt`=0.
- `tx_sr` loads the holding word if it is full (holding becomes empty), else `TX_FILL`.

ACTIVE:
- `sclk_rise`: shift `mosi` into `rx_sr` at the position set by `MSB_FIRST`; `bit_cnt`+1.
- `sclk_rise` with `bit_cnt`=DW-1: the completed word (including this bit) goes to the RX output register; `bit_cnt` wraps to 0.
- `sclk_fall` with `bit_cnt`≠0: `tx_sr` shifts one position, presenting the next bit.
- `sclk_fall` with `bit_cnt`=0 (word boundary): `tx_sr` reloads from holding or `TX_FILL`, same rule as at frame start.
- `cs_rise` → IDLE; a partial `rx_sr` word is discarded and `bit_cnt`=0.

MISO:
- `miso` is always the first-out bit of `tx_sr` (MSB if `MSB_FIRST`, else LSB).
- A reload on `cs_fall` presents bit 0 before the first SCLK rise, as Mode 0 requires.

TX handshake:
- `tx_ready` = holding empty.
- `tx_valid && tx_ready` writes the holding register.
- A write and a load in the same cycle: the load takes the old content (holding was full), so `tx_ready`=0 and no write occurs. The write proceeds only if the holding register is empty.

RX handshake:
- `rx_valid && rx_ready` clears `rx_valid`.
- A new completed word while `rx_valid`=1 and `rx_ready`=0 is dropped; the old word is retained.
- Word completion in the same cycle as `rx_ready` acceptance: the new word loads and `rx_valid` stays 1.

Simultaneous events:
- `cs_rise` together with `sclk_rise` or `sclk_fall`: `cs_rise` wins and the SCLK edge is ignored.
- `cs_fall` while ACTIVE: ignored.
- `sclk_rise` together with `sclk_fall`: impossible from upstream; behaviour is undefined.

## Timing
Reset values:
- State IDLE, `bit_cnt`=0, `rx_sr`=0.
- `tx_sr`=`TX_FILL`, holding empty.
- `miso`=first-out bit of `TX_FILL`, `miso_oe`=0.
- `tx_ready`=1, `rx_valid`=0, `rx_data`=0, `rx_ovf`=0.

Latency:
- `rx_valid`/`rx_data` update in the cycle after the enable that sampled the last bit (1 cycle).
- `miso` updates 1 cycle after `sclk_fall` or `cs_fall`.
- `miso_oe` rises 1 cycle after `cs_fall` and falls 1 cycle after `cs_rise`.

Other rules:
- The engine has no SCLK frequency limit other than edge enables arriving at least 1 cycle apart.
- Reset mid-frame returns all registers to reset values; the remainder of the frame is ignored until the next `cs_fall`.

## Configuration
- `SPI_SLV_RX_OVF_EN` defined:
  - A word dropped due to overrun sets `rx_ovf`.
  - `rx_ovf` stays set until `rst` or the next `cs_fall`.
  - If a drop coincides with `cs_fall`, set has priority.
- `SPI_SLV_RX_OVF_EN` undefined:
  - `rx_ovf` is tied to 0 and no flag register exists.
  - Drop behaviour is unchanged.

## Test plan
- **Basic word, both directions.** Preload `tx_data`=0xA5, then frame with 8 SCLK edges, MOSI=0x3C, MSB_FIRST=1.
  → `rx_data`=0x3C, `rx_valid` 1 cycle after the 8th rise; MISO bits 1,0,1,0,0,1,0,1.
- **TX underrun fill.** Frame with no `tx_valid`.
  → MISO shows 0xFF; `tx_ready` stays 1.
- **Back-to-back words.** Two words 0x12, 0x34 in one frame, `rx_ready`=1, TX words 0x55, 0xAA loaded between.
  → Two `rx_valid` pulses with the correct data; second TX word reloaded on the 8th `sclk_fall`.
- **Overrun.** `rx_ready`=0, two words 0x11, 0x22.
  → `rx_data` stays 0x11; `rx_ovf`=1 with macro, 0 without; next `cs_fall` clears it.
- **Mid-word abort.** `cs_rise` after 5 bits, then a new frame with 0x81.
  → No `rx_valid` for the partial word; next word = 0x81; `miso_oe` low 1 cycle after `cs_rise`.
- **Collision and reset.** `cs_rise` coincident with `sclk_rise`; `rst` mid-frame.
  → SCLK edge ignored, IDLE entered; after `rst` all outputs equal their reset values.
